// File: rtl/ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifetch_ctrl - instruction-fetch controller
//
// Owns the program counter and drives the word address of a combinational
// instruction ROM. Each returned word is registered into a one-entry
// valid/ready output stage toward decode. Handles branch/jump redirects,
// halt requests and fetch faults, and counts delivered instructions.
//
// Parameters
//   RESET_PC : byte PC fetched first after reset
//   IM_AW    : ROM word-address width (ROM holds 2**IM_AW words)
//
// Ports
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   im_addr/im_rdata : ROM word address (combinational) and same-cycle data
//   redirect_valid/redirect_pc : taken branch/jump and its byte target
//   halt_req         : level request to stop fetching
//   if_valid/if_ready/if_instr/if_pc : output stage handshake toward decode
//   halted           : halted with the output stage drained
//   fault/fault_pc   : sticky fetch fault and offending address
//   fetch_cnt        : instructions loaded into the output stage (mod 2**32)
// -----------------------------------------------------------------------------
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic             halted,
    output logic             fault,
    output logic [31:0]      fault_pc,
    output logic [31:0]      fetch_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] fa;
    logic        fa_bad;
    logic        redir_bad;
    logic        slot_free;

    // Misaligned, or beyond the last ROM word. Addresses never wrap into the
    // ROM, so running off the end is caught here.
    function automatic logic is_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:IM_AW+2] != '0);
    endfunction

    // The redirect only steers the ROM while running; in HALT the address
    // simply follows pc_q. if_ready is deliberately absent from this path.
    assign fa        = (state_q == ST_RUN && redirect_valid) ? redirect_pc : pc_q;
    assign im_addr   = fa[IM_AW+1:2];
    assign fa_bad    = is_illegal(fa);
    assign redir_bad = is_illegal(redirect_pc);
    assign slot_free = !valid_q || if_ready;

    always_comb begin
        // NOTE: every _d takes its _q value first, so a path that does not
        // assign it holds state instead of inferring a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (redirect_valid && fa_bad) begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                    valid_d    = 1'b0;
                end else if (redirect_valid) begin
                    // Target loads even when decode stalls: the held
                    // instruction is wrong-path and is overwritten.
                    valid_d = 1'b1;
                    instr_d = im_rdata;
                    if_pc_d = redirect_pc;
                    pc_d    = redirect_pc + 32'd4;
                    cnt_d   = cnt_q + 32'd1;
                    if (halt_req) state_d = ST_HALT;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                    if (if_ready) valid_d = 1'b0;
                end else if (slot_free && fa_bad) begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    valid_d    = 1'b0;
                end else if (slot_free) begin
                    valid_d = 1'b1;
                    instr_d = im_rdata;
                    if_pc_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            ST_HALT: begin
                if (redirect_valid && redir_bad) begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                    valid_d    = 1'b0;
                end else begin
                    // A redirect only retargets pc_q and flushes; the fetch
                    // itself happens after returning to RUN (one bubble).
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        valid_d = 1'b0;
                    end else if (if_ready) begin
                        valid_d = 1'b0;
                    end
                    if (!halt_req) state_d = ST_RUN;
                end
            end

            default: begin
                // FAULT is terminal until reset; everything holds.
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            if_pc_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = (state_q == ST_HALT) && !valid_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the single-cycle CPU. It owns the program counter, drives the word address of the combinational distributed instruction ROM, and registers each returned instruction into a one-entry valid/ready output stage toward decode. It handles branch/jump redirects, halt requests and fetch faults, and counts delivered instructions.

## Interface

- `RESET_PC`, default `32'h0000_0000`: byte PC fetched first after reset.
- `IM_AW`, default `10`: ROM word-address width; the ROM holds 2^IM_AW words.

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset: one clock; reset is asynchronous and active-low.
- `im_addr`  out  IM_AW  ROM word address, combinational.
- `im_rdata`  in  32  ROM data for `im_addr`, same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  target byte address.
- `halt_req`  in  1  level request to stop fetching.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid instruction.
- `if_ready`  in  1  decode accepts this cycle.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  byte PC of `if_instr`.
- `halted`  out  1  state is HALT and the output stage is empty.
- `fault`  out  1  sticky fetch fault.
- `fault_pc`  out  32  offending address.
- `fetch_cnt`  out  32  instructions loaded into the output stage.

## Operation

- Registers:
  - `pc_q`: next sequential fetch PC.
  - Output stage: `if_valid`, `if_instr`, `if_pc`.
  - `state`: RUN, HALT or FAULT.
  - `fault`, `fault_pc`, `fetch_cnt`.
- Fetch address:
  - `fa = (state==RUN && redirect_valid) ? redirect_pc : pc_q`.
  - `im_addr = fa[IM_AW+1:2]`.
- A fetch address is illegal if `fa[1:0]!=0` or `fa[31:IM_AW+2]!=0`.
- Output-stage slot is free when `!if_valid || if_ready`.
- RUN, per cycle, in priority order:
  1. `redirect_valid` with illegal target: go to FAULT, `fault_pc<=redirect_pc`, clear `if_valid`.
  2. `redirect_valid` with legal target: load the output stage with `im_rdata`/`redirect_pc` regardless of `if_ready`. Any held instruction is discarded as wrong path. Then `pc_q<=redirect_pc+4` and `fetch_cnt++`. If `halt_req` is also high, the next state is HALT.
  3. `halt_req`: go to HALT. No fetch; `pc_q` is unchanged. A held instruction remains until accepted.
  4. Slot free and `pc_q` illegal: go to FAULT, `fault_pc<=pc_q`, clear `if_valid`.
  5. Slot free: load `im_rdata`/`pc_q`, then `pc_q<=pc_q+4` and `fetch_cnt++`.
  6. Otherwise (stalled): hold all registers.
- HALT:
  - No fetches.
  - The output stage drains normally; `if_valid` clears when the held instruction is accepted.
  - Legal `redirect_valid`: `pc_q<=redirect_pc` and clear `if_valid` (flush). No fetch.
  - Illegal `redirect_valid`: go to FAULT as in RUN.
  - `halt_req` low: return to RUN and resume from `pc_q` on the next cycle.
  - `halted = (state==HALT) && !if_valid`.
- FAULT:
  - Terminal until `rstn`.
  - `if_valid=0`, `fault=1`; all inputs are ignored.
- Arithmetic: `pc_q+4` is 32-bit modulo. Running past the last ROM word produces an illegal address, which faults; the PC never wraps to word 0. `fetch_cnt` wraps modulo 2^32.

## Timing

- Reset values:
  - `pc_q=RESET_PC`, `state=RUN`.
  - `if_valid=0`, `if_instr=0`, `if_pc=0`.
  - `fault=0`, `fault_pc=0`, `fetch_cnt=0`, `halted=0`.
- `im_addr` is combinational from `pc_q`/`redirect_*`. There is no combinational path from `if_ready` to `im_addr`.
- Latency: an instruction appears on `if_instr` one cycle after its address is presented on `im_addr`.
- After `rstn` rises, the first clock edge loads RESET_PC's instruction. `if_valid` is high from cycle 1.
- Sustained throughput is one instruction per cycle when `if_ready` is held high.
- A redirect in RUN costs zero bubbles: the target instruction is valid on the next cycle.
- A redirect in HALT, followed by release, costs one bubble.
- Handshake:
  - While `if_valid && !if_ready`, `if_instr`/`if_pc` are stable.
  - Only a redirect or a fault may drop a held instruction.
- `rstn` asserted mid-operation clears every register immediately, including a pending instruction and `fault`.

## Test plan

- Reset, RESET_PC=0, ROM words 0..3 = A,B,C,D, `if_ready=1` -> `if_pc` sequence 0,4,8,C with `if_instr` A,B,C,D on consecutive cycles; `fetch_cnt=4`.
- `if_ready=0` for 3 cycles while `if_pc=4` -> `if_instr`/`if_pc` held stable, `im_addr=2`; release -> next `if_pc=8`, with no skipped or duplicated instruction.
- Redirect to 0x40 while stalled holding pc 8 -> next cycle `if_pc=0x40`, `if_valid=1`; pc 8 is never accepted; following `if_pc=0x44`.
- `halt_req=1` with pc 0x10 held and `if_ready=1` -> `if_valid` drops next cycle and `halted=1`. Redirect to 0x80 in HALT, then release `halt_req` -> `if_pc=0x80` after one bubble.
- Redirect to 0x102 -> `fault=1`, `fault_pc=0x102`, `if_valid=0`, state stuck. Assert `rstn` -> all outputs return to reset values.
- IM_AW=4, sequential run from 0x38 -> pc 0x38 and 0x3C delivered, then `fault=1` with `fault_pc=0x40`.
